// File: rtl/mux4_scan_ctrl.sv
// Round-robin scan sequencer for a 4:1 single-bit mux. It captures one frame and hands it off with valid/ready.
// Define MUX4_SCAN_CONTINUOUS_EN to make each accepted frame restart the scan.
module mux4_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] chan_mask,
  input  logic       mux_out,
  output logic       sel0,
  output logic       sel1,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for start, outputs hold last frame/select
  // SELECT | select driven, settle counter running, sample on last count
  // HOLD   | frame complete, frame_valid high until accepted
  typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] frame_q, frame_d;
  logic       valid_q, valid_d;
  logic       busy_q;
  logic [2:0] nxt, first;

  // Returns {found, index} of the lowest enabled channel at or above 'from'.
  function automatic logic [2:0] find_from(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i >= int'(from))) r = {1'b1, 2'(i)};
    return r;
  endfunction

`ifdef MUX4_SCAN_CONTINUOUS_EN
  logic [2:0] lowest;
  assign lowest = find_from(mask_q, 3'd0);
`endif

  assign nxt   = find_from(mask_q, {1'b0, sel_q} + 3'd1);
  assign first = find_from(chan_mask, 3'd0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    frame_d = frame_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = chan_mask;
          frame_d = 4'b0000;
          if (first[2]) begin
            state_d = SELECT;
            sel_d   = first[1:0];
            cnt_d   = 4'd0;
          end else begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
      end
      SELECT: begin
        if (cnt_q == LAST) begin
          frame_d[sel_q] = mux_out;
          cnt_d          = 4'd0;
          if (nxt[2]) begin
            sel_d = nxt[1:0];
          end else begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (valid_q && frame_ready) begin
`ifdef MUX4_SCAN_CONTINUOUS_EN
          frame_d = 4'b0000;
          if (lowest[2]) begin
            state_d = SELECT;
            sel_d   = lowest[1:0];
            cnt_d   = 4'd0;
            valid_d = 1'b0;
          end else begin
            state_d = HOLD;
            valid_d = 1'b1;
          end
`else
          valid_d = 1'b0;
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      cnt_q   <= 4'd0;
      mask_q  <= 4'b0000;
      frame_q <= 4'b0000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign sel0        = sel_q[0];
  assign sel1        = sel_q[1];
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign busy        = busy_q;

endmodule
